// File: rtl/pla_sweep_pkg.sv
// rtl/pla_sweep_pkg.sv - shared types and constants for the PLA sweep controller
package pla_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 16;
   localparam int IDX_W       = 4;
   localparam int FAIL_W      = 5;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(NUM_VECTORS);

   // Saturating increment; a sweep has at most NUM_VECTORS mismatches.
   function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] cnt);
      return (cnt >= FAIL_MAX) ? FAIL_MAX : cnt + FAIL_W'(1);
   endfunction

endpackage

// File: rtl/pla_sweep_checker.sv
// rtl/pla_sweep_checker.sv - compares sampled PLA outputs and tracks failures
module pla_sweep_checker
   import pla_sweep_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              sample,
   input  logic [IDX_W-1:0]  idx,
   input  logic              pla_y,
   input  logic              pla_z,
   input  logic [15:0]       exp_y,
   input  logic [15:0]       exp_z,
   output logic [FAIL_W-1:0] fail_count,
   output logic [IDX_W-1:0]  first_fail_idx,
   output logic              first_fail_valid
);

   logic mismatch;

   // Case-equality compare so an X/Z on the PLA outputs is treated as a failure.
   always_comb begin
      mismatch = 1'b0;
      if ((pla_y !== exp_y[idx]) || (pla_z !== exp_z[idx]))
         mismatch = 1'b1;
   end

   // Failure counter and first-failure latch, cleared at sweep start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_count       <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else if (clear) begin
         fail_count       <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else if (sample && mismatch) begin
         fail_count <= fail_inc(fail_count);
         if (!first_fail_valid) begin
            first_fail_idx   <= idx;
            first_fail_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pla_sweep_controller.sv
// rtl/pla_sweep_controller.sv - sweeps a 4-in/2-out PLA and checks its truth tables
module pla_sweep_controller
   import pla_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] exp_y,
   input  logic [15:0] exp_z,
   input  logic        pla_y,
   input  logic        pla_z,
   output logic [3:0]  pla_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] y_table,
   output logic [15:0] z_table,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail_idx,
   output logic        first_fail_valid
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam bit               NO_SETTLE   = (SETTLE_CYCLES == 0);

   state_t             state, next_state;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   counter;
   logic               start_sweep;
   logic               sample_strobe;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; abort wins over every transition while sweeping.
   always_comb begin
      next_state    = state;
      start_sweep   = 1'b0;
      sample_strobe = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_sweep = 1'b1;
               next_state  = NO_SETTLE ? SAMPLE : SETTLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (abort)              next_state = IDLE;
            else if (counter <= 1)  next_state = SAMPLE;
         end
         SAMPLE: begin
            busy = 1'b1;
            if (abort) begin
               next_state = IDLE;
            end else begin
               sample_strobe = 1'b1;
               if (idx == LAST_IDX) next_state = DONE;
               else                 next_state = NO_SETTLE ? SAMPLE : SETTLE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: vector index, PLA drive, settle timer, tables and result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         counter <= '0;
         pla_in  <= '0;
         y_table <= '0;
         z_table <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start_sweep) begin
                  idx     <= '0;
                  pla_in  <= '0;
                  counter <= SETTLE_LOAD;
                  y_table <= '0;
                  z_table <= '0;
                  pass    <= 1'b0;
               end
            end
            SETTLE: begin
               if (abort)             pass    <= 1'b0;
               else if (counter > 1)  counter <= counter - CNT_W'(1);
            end
            SAMPLE: begin
               if (abort) begin
                  pass <= 1'b0;
               end else begin
                  y_table[idx] <= pla_y;
                  z_table[idx] <= pla_z;
                  if (idx != LAST_IDX) begin
                     idx     <= idx + IDX_W'(1);
                     pla_in  <= idx + IDX_W'(1);
                     counter <= SETTLE_LOAD;
                  end
               end
            end
            DONE: pass <= (fail_count == '0);
            default: ;
         endcase
      end
   end

   pla_sweep_checker u_checker (
      .clk              (clk),
      .rst_n            (rst_n),
      .clear            (start_sweep),
      .sample           (sample_strobe),
      .idx              (idx),
      .pla_y            (pla_y),
      .pla_z            (pla_z),
      .exp_y            (exp_y),
      .exp_z            (exp_z),
      .fail_count       (fail_count),
      .first_fail_idx   (first_fail_idx),
      .first_fail_valid (first_fail_valid)
   );

endmodule

// File: tb/tb_pla_sweep_controller.sv
// tb/tb_pla_sweep_controller.sv - scoreboard bench for pla_sweep_controller
module tb_pla_sweep_controller;

   typedef struct {
      logic [15:0] y;
      logic [15:0] z;
      logic        pass;
      logic [4:0]  fc;
      logic [3:0]  ffi;
      logic        ffv;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic abort = 1'b0;
   logic fault = 1'b0;
   logic start2 = 1'b0;
   logic start0 = 1'b0;
   logic [15:0] gy = 16'h8801;
   logic [15:0] gz = 16'h4020;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   exp_t q2[$];
   exp_t q0[$];

   logic [3:0]  pla_in2, pla_in0;
   logic        pla_y2, pla_z2, pla_y0, pla_z0;
   logic        busy2, done2, pass2, busy0, done0, pass0;
   logic [15:0] y_table2, z_table2, y_table0, z_table0;
   logic [4:0]  fail_count2, fail_count0;
   logic [3:0]  ffi2, ffi0;
   logic        ffv2, ffv0;

   assign pla_y2 = gy[pla_in2] & ~(fault & (pla_in2 == 4'd11));
   assign pla_z2 = gz[pla_in2];
   assign pla_y0 = gy[pla_in0];
   assign pla_z0 = gz[pla_in0];

   pla_sweep_controller #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
      .exp_y(gy), .exp_z(gz), .pla_y(pla_y2), .pla_z(pla_z2),
      .pla_in(pla_in2), .busy(busy2), .done(done2), .pass(pass2),
      .y_table(y_table2), .z_table(z_table2), .fail_count(fail_count2),
      .first_fail_idx(ffi2), .first_fail_valid(ffv2)
   );

   pla_sweep_controller #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
      .exp_y(gy), .exp_z(gz), .pla_y(pla_y0), .pla_z(pla_z0),
      .pla_in(pla_in0), .busy(busy0), .done(done0), .pass(pass0),
      .y_table(y_table0), .z_table(z_table0), .fail_count(fail_count0),
      .first_fail_idx(ffi0), .first_fail_valid(ffv0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] y, input logic [15:0] z, input logic p,
                               input logic [4:0] fc, input logic [3:0] ffi, input logic ffv);
      exp_t e;
      e.y = y; e.z = z; e.pass = p; e.fc = fc; e.ffi = ffi; e.ffv = ffv; e.done_cyc = 0;
      return e;
   endfunction

   // Monitor for the SETTLE_CYCLES=2 instance.
   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            chk("dut2_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("dut2_done_cycle", cyc, e.done_cyc);
            chk("dut2_y_table", y_table2, e.y);
            chk("dut2_z_table", z_table2, e.z);
            chk("dut2_pass", pass2, e.pass);
            chk("dut2_fail_count", fail_count2, e.fc);
            chk("dut2_first_fail_idx", ffi2, e.ffi);
            chk("dut2_first_fail_valid", ffv2, e.ffv);
         end
      end
   end

   // Monitor for the SETTLE_CYCLES=0 instance.
   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("dut0_done_cycle", cyc, e.done_cyc);
            chk("dut0_y_table", y_table0, e.y);
            chk("dut0_z_table", z_table0, e.z);
            chk("dut0_pass", pass0, e.pass);
            chk("dut0_fail_count", fail_count0, e.fc);
            chk("dut0_first_fail_valid", ffv0, e.ffv);
         end
      end
   end

   task automatic go2(input exp_t e, input bit push);
      exp_t t;
      t = e;
      t.done_cyc = cyc + 1 + 49;
      if (push) q2.push_back(t);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic go0(input exp_t e);
      exp_t t;
      t = e;
      t.done_cyc = cyc + 1 + 17;
      q0.push_back(t);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q2.size() != 0 || q0.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, q2.size() + q0.size(), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_pla2(input logic [3:0] v);
      int n;
      n = 0;
      while (pla_in2 !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_pla_in", pla_in2, v);
   endtask

   initial begin
      exp_t good;
      good = mk(16'h8801, 16'h4020, 1'b1, 5'd0, 4'd0, 1'b0);

      repeat (3) @(negedge clk);
      chk("rst_pla_in", pla_in2, 4'd0);
      chk("rst_busy", busy2, 1'b0);
      chk("rst_done", done2, 1'b0);
      chk("rst_pass", pass2, 1'b0);
      chk("rst_tables", {y_table2, z_table2}, 32'd0);
      chk("rst_fail", {fail_count2, ffi2, ffv2}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Golden PLA, 49-cycle latency.
      go2(good, 1'b1);
      drain("t1_drain");

      // Y stuck-at-0 on vector 11.
      fault = 1'b1;
      go2(mk(16'h8001, 16'h4020, 1'b0, 5'd1, 4'd11, 1'b1), 1'b1);
      drain("t2_drain");
      fault = 1'b0;

      // No settle time: one vector per cycle.
      go0(good);
      for (int k = 0; k < 16; k++) begin
         chk("t3_pla_in_step", pla_in0, k);
         @(negedge clk);
      end
      drain("t3_drain");

      // Abort at vector 6, partial results held, then a clean restart.
      go2(good, 1'b0);
      wait_pla2(4'd6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_busy", busy2, 1'b0);
      chk("t4_pass", pass2, 1'b0);
      chk("t4_y_partial", y_table2, 16'h0001);
      chk("t4_z_partial", z_table2, 16'h0020);
      chk("t4_pla_in_held", pla_in2, 4'd6);
      repeat (5) @(negedge clk);
      go2(good, 1'b1);
      chk("t4_restart_pla_in", pla_in2, 4'd0);
      chk("t4_restart_y_clear", y_table2, 16'h0000);
      chk("t4_restart_busy", busy2, 1'b1);
      drain("t4_drain");

      // Start pulse mid-sweep is ignored.
      go2(good, 1'b1);
      wait_pla2(4'd3);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      drain("t5_drain");

      // Asynchronous reset mid-settle.
      go2(good, 1'b0);
      wait_pla2(4'd4);
      chk("t6_pre_y", y_table2, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_pla_in", pla_in2, 4'd0);
      chk("t6_busy", busy2, 1'b0);
      chk("t6_done", done2, 1'b0);
      chk("t6_pass", pass2, 1'b0);
      chk("t6_tables", {y_table2, z_table2}, 32'd0);
      chk("t6_fail", {fail_count2, ffi2, ffv2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("t6_idle_busy", busy2, 1'b0);
      chk("t6_idle_pla_in", pla_in2, 4'd0);
      chk("final_queues", q2.size() + q0.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
